// File: rtl/regfile_port_ctrl.sv
// Access controller for a 16 x 16-bit register array: one-hot read/write
// decode, write-to-read bypass, optional R0 hardwiring and a sequenced clear.
module regfile_port_ctrl #(
    parameter bit READ_ZERO_R0 = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReadReq,
    input  logic [3:0]  SrcReg1,
    input  logic [3:0]  SrcReg2,
    input  logic        WriteReq,
    input  logic [3:0]  DstReg,
    input  logic [15:0] DstData,
    input  logic        ClearReq,
    input  logic [15:0] Bitline1,
    input  logic [15:0] Bitline2,
    output logic [15:0] WriteReg,
    output logic [15:0] D,
    output logic [15:0] ReadEnable1,
    output logic [15:0] ReadEnable2,
    output logic [15:0] SrcData1,
    output logic [15:0] SrcData2,
    output logic        ReadValid,
    output logic        Ready
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] src1_q, src1_d;
    logic [15:0] src2_q, src2_d;
    logic        valid_q, valid_d;
    logic        wr_ok_s;
    logic        r0_src1_s;
    logic        r0_src2_s;

    function automatic logic [15:0] onehot(input logic [3:0] id);
        onehot = 16'h0001 << id;
    endfunction

    assign SrcData1  = src1_q;
    assign SrcData2  = src2_q;
    assign ReadValid = valid_q;

    // Array drive, read-data selection and clear sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        valid_d     = 1'b0;
        WriteReg    = 16'h0000;
        D           = 16'h0000;
        ReadEnable1 = 16'h0000;
        ReadEnable2 = 16'h0000;
        Ready       = 1'b0;
        wr_ok_s     = WriteReq && !(READ_ZERO_R0 && (DstReg == 4'd0));
        r0_src1_s   = READ_ZERO_R0 && (SrcReg1 == 4'd0);
        r0_src2_s   = READ_ZERO_R0 && (SrcReg2 == 4'd0);
        if (rst) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    Ready = 1'b1;
                    if (WriteReq) begin
                        D = DstData;
                    end else begin
                        D = 16'h0000;
                    end
                    if (wr_ok_s) begin
                        WriteReg = onehot(DstReg);
                    end else begin
                        WriteReg = 16'h0000;
                    end
                    if (ReadReq) begin
                        valid_d = 1'b1;
                        // A hardwired R0 leaves its bitline floating, so the data is forced here
                        if (r0_src1_s) begin
                            src1_d = 16'h0000;
                        end else if (wr_ok_s && (DstReg == SrcReg1)) begin
                            src1_d      = DstData;
                            ReadEnable1 = onehot(SrcReg1);
                        end else begin
                            src1_d      = Bitline1;
                            ReadEnable1 = onehot(SrcReg1);
                        end
                        if (r0_src2_s) begin
                            src2_d = 16'h0000;
                        end else if (wr_ok_s && (DstReg == SrcReg2)) begin
                            src2_d      = DstData;
                            ReadEnable2 = onehot(SrcReg2);
                        end else begin
                            src2_d      = Bitline2;
                            ReadEnable2 = onehot(SrcReg2);
                        end
                    end else begin
                        valid_d = 1'b0;
                    end
                    if (ClearReq) begin
                        state_d = CLEAR;
                        cnt_d   = READ_ZERO_R0 ? 4'd1 : 4'd0;
                    end else begin
                        state_d = RUN;
                    end
                end
                CLEAR: begin
                    WriteReg = onehot(cnt_q);
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = RUN;
                    end else begin
                        state_d = CLEAR;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State, counter and registered read outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            src1_q  <= 16'h0000;
            src2_q  <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: behavioural register-array environment plus a
// reference model of the controller's architectural behaviour.
module tb_regfile_port_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ReadReq = 1'b0;
    logic [3:0]  SrcReg1 = 4'd0;
    logic [3:0]  SrcReg2 = 4'd0;
    logic        WriteReq = 1'b0;
    logic [3:0]  DstReg = 4'd0;
    logic [15:0] DstData = 16'h0000;
    logic        ClearReq = 1'b0;
    logic [15:0] Bitline1;
    logic [15:0] Bitline2;
    logic [15:0] WriteReg;
    logic [15:0] D;
    logic [15:0] ReadEnable1;
    logic [15:0] ReadEnable2;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;
    logic        ReadValid;
    logic        Ready;

    int total = 0;
    int bad   = 0;

    // physical array driven by the DUT
    logic [15:0] arr [16] = '{default: 16'h0000};
    // reference model state
    logic [15:0] ref_mem [16] = '{default: 16'h0000};
    bit          m_clr = 1'b0;
    int          m_idx = 0;
    logic [15:0] m_s1 = 16'h0000;
    logic [15:0] m_s2 = 16'h0000;
    logic        m_v = 1'b0;

    always #5 clk = ~clk;

    regfile_port_ctrl dut (
        .clk(clk), .rst(rst), .ReadReq(ReadReq), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .WriteReq(WriteReq), .DstReg(DstReg), .DstData(DstData), .ClearReq(ClearReq),
        .Bitline1(Bitline1), .Bitline2(Bitline2), .WriteReg(WriteReg), .D(D),
        .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
        .SrcData1(SrcData1), .SrcData2(SrcData2), .ReadValid(ReadValid), .Ready(Ready)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (WriteReg[i]) arr[i] <= D;
        end
    end

    // an unselected bitline floats high
    always_comb begin
        Bitline1 = 16'hFFFF;
        Bitline2 = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            if (ReadEnable1[i]) Bitline1 = arr[i];
            if (ReadEnable2[i]) Bitline2 = arr[i];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sel(input int id);
        sel = 16'(32'd1 << id);
    endfunction

    task automatic step(input bit rr, input int s1, input int s2, input bit wr,
                        input int dst, input logic [15:0] data, input bit clr);
        logic [15:0] e_wr, e_d, e_re1, e_re2;
        bit wr_eff;
        ReadReq  = rr;
        SrcReg1  = s1[3:0];
        SrcReg2  = s2[3:0];
        WriteReq = wr;
        DstReg   = dst[3:0];
        DstData  = data;
        ClearReq = clr;
        #1;
        wr_eff = !m_clr && wr && (dst != 0);
        e_wr  = m_clr ? sel(m_idx) : (wr_eff ? sel(dst) : 16'h0000);
        e_d   = (!m_clr && wr) ? data : 16'h0000;
        e_re1 = (!m_clr && rr && s1 != 0) ? sel(s1) : 16'h0000;
        e_re2 = (!m_clr && rr && s2 != 0) ? sel(s2) : 16'h0000;
        chk("ready", {15'd0, Ready}, {15'd0, !m_clr});
        chk("writereg", WriteReg, e_wr);
        chk("d", D, e_d);
        chk("re1", ReadEnable1, e_re1);
        chk("re2", ReadEnable2, e_re2);
        if (!m_clr) begin
            if (rr) begin
                m_s1 = (s1 == 0) ? 16'h0000 : ((wr_eff && dst == s1) ? data : ref_mem[s1]);
                m_s2 = (s2 == 0) ? 16'h0000 : ((wr_eff && dst == s2) ? data : ref_mem[s2]);
                m_v  = 1'b1;
            end else begin
                m_v = 1'b0;
            end
            if (wr_eff) ref_mem[dst] = data;
            if (clr) begin
                m_clr = 1'b1;
                m_idx = 1;
            end
        end else begin
            ref_mem[m_idx] = 16'h0000;
            m_v = 1'b0;
            if (m_idx == 15) m_clr = 1'b0;
            else m_idx++;
        end
        @(posedge clk);
        #1;
        chk("srcdata1", SrcData1, m_s1);
        chk("srcdata2", SrcData2, m_s2);
        chk("readvalid", {15'd0, ReadValid}, {15'd0, m_v});
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 0, 16'h0000, 1'b0);
    endtask

    // asynchronous reset raised mid-cycle while requests are active
    task automatic reset_mid();
        ReadReq  = 1'b1;
        SrcReg1  = 4'd7;
        SrcReg2  = 4'd9;
        WriteReq = 1'b1;
        DstReg   = 4'd7;
        DstData  = 16'hA5A5;
        ClearReq = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_writereg", WriteReg, 16'h0000);
        chk("rst_d", D, 16'h0000);
        chk("rst_re1", ReadEnable1, 16'h0000);
        chk("rst_re2", ReadEnable2, 16'h0000);
        chk("rst_ready", {15'd0, Ready}, 16'h0000);
        chk("rst_src1", SrcData1, 16'h0000);
        chk("rst_src2", SrcData2, 16'h0000);
        chk("rst_valid", {15'd0, ReadValid}, 16'h0000);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ReadReq  = 1'b0;
        WriteReq = 1'b0;
        ClearReq = 1'b0;
        m_clr = 1'b0;
        m_s1  = 16'h0000;
        m_s2  = 16'h0000;
        m_v   = 1'b0;
        #1;
        chk("post_rst_ready", {15'd0, Ready}, 16'h0001);
        chk("post_rst_src1", SrcData1, 16'h0000);
        chk("post_rst_valid", {15'd0, ReadValid}, 16'h0000);
    endtask

    initial begin
        // reset state
        #3;
        chk("init_writereg", WriteReg, 16'h0000);
        chk("init_re1", ReadEnable1, 16'h0000);
        chk("init_d", D, 16'h0000);
        chk("init_ready", {15'd0, Ready}, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("deassert_ready", {15'd0, Ready}, 16'h0001);
        chk("deassert_src1", SrcData1, 16'h0000);
        chk("deassert_valid", {15'd0, ReadValid}, 16'h0000);

        // write then read back on both ports
        step(1'b0, 0, 0, 1'b1, 3, 16'hBEEF, 1'b0);
        step(1'b1, 3, 3, 1'b0, 0, 16'h0000, 1'b0);
        idle();

        // bypass on port 1 only
        step(1'b0, 0, 0, 1'b1, 5, 16'h1111, 1'b0);
        step(1'b0, 0, 0, 1'b1, 6, 16'h3333, 1'b0);
        step(1'b1, 5, 6, 1'b1, 5, 16'h2222, 1'b0);
        step(1'b1, 5, 5, 1'b0, 0, 16'h0000, 1'b0);
        // bypass on both ports
        step(1'b1, 6, 6, 1'b1, 6, 16'h4444, 1'b0);

        // R0 hardwired
        step(1'b0, 0, 0, 1'b1, 0, 16'hFFFF, 1'b0);
        step(1'b1, 0, 3, 1'b1, 0, 16'h5555, 1'b0);
        step(1'b1, 0, 0, 1'b0, 0, 16'h0000, 1'b0);

        reset_mid();
        step(1'b1, 7, 3, 1'b0, 0, 16'h0000, 1'b0);

        // full clear, requests during the clear are ignored
        for (int i = 1; i < 16; i++) step(1'b0, 0, 0, 1'b1, i, 16'($urandom) | 16'h0001, 1'b0);
        step(1'b0, 0, 0, 1'b0, 0, 16'h0000, 1'b1);
        for (int i = 0; i < 15; i++)
            step(1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 1'b1,
                 $urandom_range(1, 15), 16'($urandom), 1'($urandom));
        for (int i = 0; i < 16; i++) step(1'b1, i, (i + 1) % 16, 1'b0, 0, 16'h0000, 1'b0);
        idle();

        // clear abandoned by reset after 5 clear cycles
        for (int i = 1; i < 16; i++) step(1'b0, 0, 0, 1'b1, i, 16'($urandom) | 16'h8000, 1'b0);
        step(1'b0, 0, 0, 1'b0, 0, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) idle();
        reset_mid();
        for (int i = 0; i < 3; i++) idle();
        for (int i = 0; i < 16; i += 2) step(1'b1, i, i + 1, 1'b0, 0, 16'h0000, 1'b0);
        idle();

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
                 $urandom_range(0, 15), 16'($urandom), ($urandom_range(0, 49) == 0));
        for (int i = 0; i < 17; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
